// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU in the EX stage. It produces one quotient bit per
// clock and returns {remainder, quotient} for the HI/LO write.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quot_abs, rem_abs, quot_fix, rem_fix;

  // The most negative operand negates to itself, so its unsigned bit pattern goes to the array.
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The partial remainder stays below twice the divisor, so bit WIDTH of diff is its sign.
  assign diff     = dividend_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
  assign quot_abs = dividend_q[WIDTH-1:0];
  assign rem_abs  = dividend_q[2*WIDTH:WIDTH+1];
  assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quot_abs : quot_abs;
  assign rem_fix  = (signed_q && sign1_q) ? -rem_abs : rem_abs;

  always_comb begin
    // NOTE: every _d gets a hold value first so that no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    signed_d   = signed_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      S_IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_RUN;
            cnt_d      = '0;
            divisor_d  = abs2;
            dividend_d = {{WIDTH{1'b0}}, abs1, 1'b0};
            sign1_d    = opdata1_i[WIDTH-1];
            sign2_d    = opdata2_i[WIDTH-1];
            signed_d   = signed_div_i;
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_DONE;
        result_d = '0;
        ready_d  = 1'b1;
      end

      S_RUN: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CW'(WIDTH)) begin
          if (diff[WIDTH]) begin
            dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
          end else begin
            dividend_d = {diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end

      S_DONE: begin
        if (!start_i || annul_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random DIV/DIVU operations
// checked against plain integer division for results and a fixed cycle count for latency.
module tb_ex_div;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int checks = 0;
  int errors = 0;

  ex_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via 64-bit integer arithmetic, zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic sd, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == '0) return 64'd0;
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // One full operation: start held until ready_o, optional hold in DONE, then release.
  task automatic run_div(input string tag, input logic sd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold, input bit scramble);
    logic [63:0] exp;
    int n;
    int lat_exp;
    exp     = ref_div(sd, a, b);
    lat_exp = (b == '0) ? 2 : W + 2;
    @(negedge clk);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && n < 100);
    check({tag, " latency"}, 64'(n), 64'(lat_exp));
    check({tag, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    end
    start_i = 1'b0;
    @(negedge clk);
    check({tag, " release"}, {result_o, 1'b0} | 65'(ready_o), 65'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rs;

    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    rst = 1'b0;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    check("divu 100/7 literal", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 0, 1'b0);
    run_div("div 5/0", 1'b1, 32'd5, 32'd0, 0, 1'b0);

    // start together with annul in IDLE must be ignored
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    repeat (3) begin
      @(negedge clk);
      check("idle annul ready", 64'(ready_o), 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;

    // annul seen at edge 10 of the operation
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (n = 1; n < 10; n++) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul result", result_o, 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("annul stays idle", 64'(ready_o), 64'd0);
    end
    run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 0, 1'b0);

    // reset asserted at edge 20 of the operation
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd17;
    start_i = 1'b1;
    for (n = 1; n < 20; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun reset result", result_o, 64'd0);
    check("midrun reset ready", 64'(ready_o), 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("post reset ready", 64'(ready_o), 64'd0);
    run_div("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    check("overflow literal", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF),
          64'h00000000_80000000);

    run_div("done hold", 1'b0, 32'hDEADBEEF, 32'd1234, 5, 1'b0);
    run_div("scramble", 1'b1, 32'hF0000001, 32'd77, 0, 1'b1);
    run_div("div minneg/2", 1'b1, 32'h80000000, 32'd2, 0, 1'b0);
    run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
    run_div("divu small/large", 1'b0, 32'd5, 32'hFFFFFFFF, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2, 3: rb = $urandom_range(1, 15);
        4:       rb = 32'hFFFFFFFF - $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      run_div("random", rs, ra, rb, 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
